// File: rtl/mont_reduce_if.sv
// Handshake and operand bus for the Montgomery out-of-domain reducer.
// The master drives the start request and operands; the slave returns the result and a done pulse.
interface mont_reduce_if #(
    parameter int BITS = 256
);
    logic            i_start;
    logic [BITS-1:0] i_n;
    logic [BITS-1:0] i_a;
    logic [BITS-1:0] o_a;
    logic            o_end;

    modport master (output i_start, i_n, i_a, input o_a, o_end);
    modport slave  (input i_start, i_n, i_a, output o_a, o_end);
endinterface

// File: rtl/mont_reduce.sv
// Montgomery out-of-domain conversion: o_a = i_a * 2^(-BITS) mod N.
// Bit-serial radix-2 reduction, one iteration per clock, then a single conditional subtract.
module mont_reduce #(
    parameter int BITS = 256
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mont_reduce_if.slave bus
);
    localparam int CW = $clog2(BITS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOP, S_FIX} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [BITS:0]   m, m_nxt;
    logic [BITS-1:0] n_reg, n_nxt;
    logic [BITS-1:0] o_a_q, o_a_nxt;
    logic            o_end_q, o_end_nxt;
    logic [BITS+1:0] t_sum;
    logic            last_iter;

    // Odd N makes the sum even when m is odd, so the halving is exact modulo N.
    assign t_sum     = m[0] ? ({1'b0, m} + {2'b0, n_reg}) : {1'b0, m};
    assign last_iter = (cnt == CW'(BITS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.i_start) state_nxt = S_LOOP;
            S_LOOP:  if (last_iter)   state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every variable gets a hold-value default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_nxt   = cnt;
        m_nxt     = m;
        n_nxt     = n_reg;
        o_a_nxt   = o_a_q;
        o_end_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    m_nxt   = {1'b0, bus.i_a};
                    n_nxt   = bus.i_n;
                    cnt_nxt = '0;
                end
            end
            S_LOOP: begin
                m_nxt   = (BITS + 1)'(t_sum >> 1);
                cnt_nxt = cnt + 1'b1;
            end
            S_FIX: begin
                // After BITS iterations m <= N, so one subtraction lands in [0, N-1].
                o_a_nxt   = (m >= {1'b0, n_reg}) ? BITS'(m - {1'b0, n_reg}) : BITS'(m);
                o_end_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the wide operand registers are reset too, so a mid-operation reset leaves no stale data visible.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt     <= '0;
            m       <= '0;
            n_reg   <= '0;
            o_a_q   <= '0;
            o_end_q <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            m       <= m_nxt;
            n_reg   <= n_nxt;
            o_a_q   <= o_a_nxt;
            o_end_q <= o_end_nxt;
        end
    end

    assign bus.o_a   = o_a_q;
    assign bus.o_end = o_end_q;
endmodule
